// File: rtl/npu_sram_pkg.sv
// Shared widths, FSM state encoding and FIFO entry layout for the NPU SRAM
// s2 burst reader.
package npu_sram_pkg;

    localparam int ADDR_W = 14;  // SRAM word address, 16384 words
    localparam int DATA_W = 16;  // SRAM word width
    localparam int LEN_W  = 15;  // command length, 0..16384 words

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // One returned word plus the tag marking the final word of a command.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rd_data whenever
// the FIFO is not empty, and rd_en pops it. DEPTH must be a power of two.
module npu_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage write; entries are qualified by count, so contents need no clear.
    // NOTE: storage arrays are deliberately not reset -- only pointers and count define validity, and a reset on the array would stop it mapping to RAM/cheap flops.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
        end
    end

endmodule

// File: rtl/npu_sram_burst_reader.sv
// Avalon-MM read master for SRAM port s2. A command (base address, length)
// becomes a run of single-word reads, one per cycle while credit allows; the
// returned words are delivered in order on a valid/ready stream.
module npu_sram_burst_reader
    import npu_sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // SRAM s2 master
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [1:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    // output stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    // status
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              drain_done;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;

    // Read-only master: the write side of the port is permanently idle.
    assign avm_write      = 1'b0;
    assign avm_byteenable = 2'b11;
    assign avm_writedata  = '0;
    assign avm_clken      = 1'b1;

    assign avm_address    = addr_q;
    assign avm_chipselect = issue;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign head      = fifo_entry_t'(head_bits);
    assign out_data  = head.data;
    assign out_last  = out_valid && head.last;

    assign busy = (state_q != IDLE);
    assign done = done_q;

    // Every issued word needs a FIFO slot when it returns next cycle: count the
    // word already in flight, and free the slot the head vacates this cycle.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign credit_ok   = (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic and per-cycle strobes.
    // NOTE: every signal driven here gets a default first, so no path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state_q;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len != '0) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (remaining_q != '0 && credit_ok) begin
                    issue = 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last-tagged word is the final FIFO entry, so its pop
                // also leaves the FIFO empty.
                if (pop && head.last) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command address/length tracking, in-flight read flag and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                remaining_q <= remaining_q - LEN_W'(1);
            end
            // Read latency is exactly one cycle: the flag set by an issue is
            // consumed by the capture on the following edge.
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == LEN_W'(1));
            done_q          <= (accept && (cmd_len == '0)) || drain_done;
        end
    end

    assign wr_entry = '{last: inflight_last_q, data: avm_readdata};

    npu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight_q),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head_bits),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_npu_sram_burst_reader.sv
// Scoreboard bench for npu_sram_burst_reader: the stimulus process queues the
// expected {last, data} words; a negedge monitor pops and compares each beat.
`timescale 1ns/1ps
module tb_npu_sram_burst_reader;
    import npu_sram_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [1:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // scoreboard and monitor bookkeeping
    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    int   e0;
    int   beats;
    int   cs_count;
    int   valid_count;
    int   done_count;
    int   done_start;
    int   done_cyc;
    int   cs_first;
    int   val_first;
    bit   cs_seen;
    bit   val_seen;
    int   outstanding;
    bit   prev_stall;
    logic [DATA_W:0] prev_word;

    // ready pattern driver control
    bit        rdy_toggle = 1'b0;
    logic [3:0] rdy_pat   = 4'b1001;  // phases 0..3 -> 1,0,0,1
    logic [1:0] rdy_phase = 2'd0;

    npu_sram_burst_reader #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        return {2'b00, a} ^ 16'hA5A5;
    endfunction

    // SRAM s2 model: fixed read latency of one cycle.
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= sram_word(avm_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: beats, handshake stability, credit invariant, done pulses.
    always @(negedge clk) begin
        bit pop;
        logic [DATA_W:0] exp_word;
        if (reset) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop = out_valid && out_ready;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", {out_last, out_data}, prev_word);
            end
            if (avm_chipselect) begin
                if (!cs_seen) begin cs_seen = 1'b1; cs_first = cyc; end
                cs_count++;
                addr_log.push_back(avm_address);
                check("credit", ((outstanding - int'(pop)) < 4), 1);
            end
            if (out_valid) begin
                if (!val_seen) begin val_seen = 1'b1; val_first = cyc; end
                valid_count++;
            end
            if (pop) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h with no word expected", {out_last, out_data});
                end else begin
                    exp_word = exp_q.pop_front();
                    check("beat", {out_last, out_data}, exp_word);
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
            outstanding = outstanding + int'(avm_chipselect) - int'(pop);
            prev_stall  = out_valid && !out_ready;
            prev_word   = {out_last, out_data};
        end
    end

    // out_ready driver: held high, or cycling through rdy_pat.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                out_ready = rdy_pat[rdy_phase];
                rdy_phase = rdy_phase + 2'd1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk);
        #1;
        cs_seen    = 1'b0;
        val_seen   = 1'b0;
        beats      = 0;
        done_start = done_count;
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = l;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        e0        = cyc;
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, (l != '0));
    endtask

    // Wait (bounded) for the done pulse; exp_off < 0 skips the timing check.
    task automatic wait_done(input string name, input int exp_off, input int budget);
        int n = 0;
        while (done_count == done_start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_count == done_start) begin
            check({name, "_timeout"}, done_count - done_start, 1);
        end else if (exp_off >= 0) begin
            check(name, done_cyc - e0, exp_off);
        end
        repeat (3) @(posedge clk);
        check({name, "_once"}, done_count - done_start, 1);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr [4];
        int snap_cs;
        int snap_val;
        int n;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        done_count = 0;
        cs_count   = 0;
        valid_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_chipselect", avm_chipselect, 0);
        check("rst_address", avm_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("tie_write", avm_write, 0);
        check("tie_byteenable", avm_byteenable, 2'b11);
        check("tie_writedata", avm_writedata, 0);
        check("tie_clken", avm_clken, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: addr 0x0010 len 4, ready high
        exp_q.push_back({1'b0, 16'hA5B5});
        exp_q.push_back({1'b0, 16'hA5B4});
        exp_q.push_back({1'b0, 16'hA5B7});
        exp_q.push_back({1'b1, 16'hA5B6});
        send_cmd(14'h0010, 15'd4);
        wait_done("t1_done", 6, 50);
        check("t1_first_cs", cs_first - e0, 0);
        check("t1_first_valid", val_first - e0, 2);
        check("t1_beats", beats, 4);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: address wrap at the top of the SRAM
        exp_addr = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        addr_log.delete();
        exp_q.push_back({1'b0, 16'h9A5B});
        exp_q.push_back({1'b0, 16'h9A5A});
        exp_q.push_back({1'b0, 16'hA5A5});
        exp_q.push_back({1'b1, 16'hA5A4});
        send_cmd(14'h3FFE, 15'd4);
        wait_done("t2_done", 6, 50);
        check("t2_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            check("t2_addr", addr_log[i], exp_addr[i]);
        end
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: len 16 under 1,0,0,1 backpressure; commands while busy are ignored
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({(k == 15), sram_word(14'h0200 + 14'(k))});
        end
        rdy_toggle = 1'b1;
        send_cmd(14'h0200, 15'd16);
        cmd_valid = 1'b1;
        cmd_addr  = 14'h1234;
        cmd_len   = 15'd5;
        repeat (4) begin
            @(negedge clk);
            check("t3_cmd_ready_busy", cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done("t3_done", -1, 200);
        rdy_toggle = 1'b0;
        check("t3_beats", beats, 16);
        check("t3_sb_empty", exp_q.size(), 0);

        // 4: zero-length command
        snap_cs  = cs_count;
        snap_val = valid_count;
        send_cmd(14'h0055, 15'd0);
        wait_done("t4_done", 0, 20);
        check("t4_no_chipselect", cs_count - snap_cs, 0);
        check("t4_no_valid", valid_count - snap_val, 0);
        @(negedge clk);
        check("t4_cmd_ready", cmd_ready, 1);

        // 5: reset after 3 of 10 words, then a fresh 2-word command
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({(k == 9), sram_word(14'h0300 + 14'(k))});
        end
        send_cmd(14'h0300, 15'd10);
        n = 0;
        while (beats < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_3", (beats >= 3), 1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_cmd_ready", cmd_ready, 1);
        check("t5_rst_chipselect", avm_chipselect, 0);
        check("t5_rst_address", avm_address, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_last", out_last, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back({1'b0, 16'hA4A5});
        exp_q.push_back({1'b1, 16'hA4A4});
        send_cmd(14'h0100, 15'd2);
        wait_done("t5_done", 4, 30);
        check("t5_beats", beats, 2);
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: full-memory command at one word per cycle
        for (int k = 0; k < 16384; k++) begin
            exp_q.push_back({(k == 16383), sram_word(14'(k))});
        end
        send_cmd(14'h0000, 15'd16384);
        wait_done("t6_done", 16386, 16500);
        check("t6_first_valid", val_first - e0, 2);
        check("t6_beats", beats, 16384);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
